// File: rtl/nt_bist_pkg.sv
// Shared definitions for the Nt-node subcircuit BIST driver.
package nt_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRST,
    S_RUN,
    S_FLUSH,
    S_CHECK,
    S_DONE
  } state_e;

  // Taps 16,14,13,11 of a maximal-length 16-bit polynomial.
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam int          DUT_RST_LEN = 2;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s, input logic si);
    return {s[14:0], (^(s & LFSR_TAPS)) ^ si};
  endfunction

endpackage

// File: rtl/nt_lfsr16.sv
// 16-bit Fibonacci shift register with seed load and serial-in XOR.
// Serial-in tied low gives a pattern generator; fed with a response bit it compacts a signature.
module nt_lfsr16
  import nt_bist_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [15:0]      seed_i,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic             si_i,
  output logic [OUT_W-1:0] state_o
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (adv_i) begin
      state_d = lfsr_step(state_q, si_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= seed_i;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/nt_subckt_bist.sv
// BIST driver: resets the subcircuit, drives LFSR patterns, compacts its response into a MISR
// and compares the final signature against GOLDEN.
module nt_subckt_bist
  import nt_bist_pkg::*;
#(
  parameter int          N_IN     = 5,
  parameter int          PATTERNS = 1000,
  parameter int          LAT      = 2,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter logic [15:0] GOLDEN   = 16'h0000
) (
  input  logic            I1470,
  input  logic            I1477,
  input  logic            start,
  output logic            dut_rst,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     signature
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] P_LAST   = 16'(PATTERNS - 1);
  localparam logic [15:0] LAT_LAST = 16'(LAT - 1);
  localparam logic [15:0] RST_LAST = 16'(DUT_RST_LEN - 1);
  localparam logic [16:0] LAT17    = 17'(LAT);

  state_e          state_q;
  logic [15:0]     cnt_q;
  logic            dut_rst_q, busy_q, done_q, pass_q;
  logic [N_IN-1:0] dut_in_q;
  logic [15:0]     sig_q;
  logic [N_IN-1:0] pat_w;
  logic [15:0]     misr_w;
  logic            seed_ld, pat_adv, misr_en;

  // The generator runs one step ahead of dut_in_q, so it stops on the last RUN cycle
  // and dut_in_q keeps the final pattern through FLUSH.
  assign seed_ld = (state_q == S_DRST) && (cnt_q == 16'd0);
  assign pat_adv = ((state_q == S_DRST) && (cnt_q == RST_LAST)) ||
                   ((state_q == S_RUN) && (cnt_q != P_LAST));
  assign misr_en = ((state_q == S_RUN) && (({1'b0, cnt_q} + 17'd1) > LAT17)) ||
                   (state_q == S_FLUSH);

  nt_lfsr16 #(.OUT_W(N_IN)) u_gen (
    .clk_i  (I1470),
    .rst_i  (I1477),
    .seed_i (SEED_EFF),
    .load_i (seed_ld),
    .adv_i  (pat_adv),
    .si_i   (1'b0),
    .state_o(pat_w)
  );

  nt_lfsr16 #(.OUT_W(16)) u_misr (
    .clk_i  (I1470),
    .rst_i  (I1477),
    .seed_i (16'h0000),
    .load_i (seed_ld),
    .adv_i  (misr_en),
    .si_i   (dut_out),
    .state_o(misr_w)
  );

  always_ff @(posedge I1470) begin
    if (I1477) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      dut_rst_q <= 1'b1;
      dut_in_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      sig_q     <= 16'h0000;
    end else begin
      cnt_q     <= cnt_q + 16'd1;
      dut_rst_q <= 1'b0;
      dut_in_q  <= '0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_DRST;
            cnt_q     <= 16'd0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            dut_rst_q <= 1'b1;
          end
        end
        S_DRST: begin
          if (cnt_q == RST_LAST) begin
            state_q  <= S_RUN;
            cnt_q    <= 16'd0;
            dut_in_q <= pat_w;
          end else begin
            dut_rst_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (cnt_q == P_LAST) begin
            cnt_q <= 16'd0;
            if (LAT == 0) begin
              state_q <= S_CHECK;
            end else begin
              state_q  <= S_FLUSH;
              dut_in_q <= dut_in_q;
            end
          end else begin
            dut_in_q <= pat_w;
          end
        end
        S_FLUSH: begin
          if (cnt_q == LAT_LAST) begin
            state_q <= S_CHECK;
            cnt_q   <= 16'd0;
          end else begin
            dut_in_q <= dut_in_q;
          end
        end
        S_CHECK: begin
          state_q <= S_DONE;
          cnt_q   <= 16'd0;
          sig_q   <= misr_w;
          pass_q  <= (misr_w == GOLDEN);
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 16'd0;
        end
      endcase
    end
  end

  assign dut_rst   = dut_rst_q;
  assign dut_in    = dut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_nt_subckt_bist.sv
// Bench for nt_subckt_bist: five parameterisations checked every cycle against a
// timeline model (cycles since an accepted start) plus software LFSR/MISR signatures.
module tb_nt_subckt_bist;

  localparam int NI = 5;

  function automatic logic [15:0] nxt(input logic [15:0] s, input logic b);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ b};
  endfunction

  // Signature of P patterns, each response aligned to its own pattern.
  // mode 0: response 0; mode 1: pattern bit 0; mode 2: bit0 ^ bit1.
  function automatic logic [15:0] ref_sig(input logic [15:0] seed, input int p, input int mode);
    logic [15:0] g;
    logic [15:0] m;
    logic r;
    g = (seed == 16'h0000) ? 16'h0001 : seed;
    m = 16'h0000;
    for (int j = 0; j < p; j++) begin
      r = (mode == 0) ? 1'b0 : (mode == 1) ? g[0] : (g[0] ^ g[1]);
      m = nxt(m, r);
      g = nxt(g, 1'b0);
    end
    return m;
  endfunction

  localparam int          PP [NI] = '{1000, 16, 16, 20, 8};
  localparam int          LL [NI] = '{2, 2, 2, 1, 0};
  localparam int          NN [NI] = '{5, 5, 5, 3, 5};
  localparam int          MD [NI] = '{0, 1, 1, 1, 2};
  localparam logic [15:0] SS [NI] = '{16'hACE1, 16'hACE1, 16'hACE1, 16'h0000, 16'h1234};
  localparam logic [15:0] GB      = ref_sig(16'hACE1, 16, 1);
  localparam logic [15:0] GG [NI] = '{16'h0000, GB ^ 16'h0001, GB, 16'hBEEF, 16'h0000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic st0 = 1'b0, stB = 1'b0, stC = 1'b0, stD = 1'b0;
  logic rst0 = 1'b1, rstB = 1'b1, rstC = 1'b1, rstD = 1'b1;
  logic st_a [NI];
  logic rst_a [NI];
  assign st_a[0] = st0;  assign rst_a[0] = rst0;
  assign st_a[1] = stB;  assign rst_a[1] = rstB;
  assign st_a[2] = stB;  assign rst_a[2] = rstB;
  assign st_a[3] = stC;  assign rst_a[3] = rstC;
  assign st_a[4] = stD;  assign rst_a[4] = rstD;

  logic        drst_o [NI];
  logic        busy_o [NI];
  logic        done_o [NI];
  logic        pass_o [NI];
  logic [15:0] sig_o  [NI];
  logic [15:0] din_o  [NI];
  logic        dout   [NI];
  logic        h1 [NI];
  logic        h2 [NI];
  logic [4:0]  din_a, din_b, din_b2, din_d;
  logic [2:0]  din_c;

  assign din_o[0] = {11'd0, din_a};
  assign din_o[1] = {11'd0, din_b};
  assign din_o[2] = {11'd0, din_b2};
  assign din_o[3] = {13'd0, din_c};
  assign din_o[4] = {11'd0, din_d};

  // Stub DUTs: response is pattern bit 0 delayed by LAT, or a combinational mix for LAT=0.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      h1[i] <= din_o[i][0];
      h2[i] <= h1[i];
    end
  end
  assign dout[0] = 1'b0;
  assign dout[1] = h2[1];
  assign dout[2] = h2[2];
  assign dout[3] = h1[3];
  assign dout[4] = din_o[4][0] ^ din_o[4][1];

  nt_subckt_bist #(.N_IN(NN[0]), .PATTERNS(PP[0]), .LAT(LL[0]), .SEED(SS[0]), .GOLDEN(GG[0])) u_a (
    .I1470(clk), .I1477(rst_a[0]), .start(st_a[0]), .dut_rst(drst_o[0]), .dut_in(din_a),
    .dut_out(dout[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .signature(sig_o[0]));
  nt_subckt_bist #(.N_IN(NN[1]), .PATTERNS(PP[1]), .LAT(LL[1]), .SEED(SS[1]), .GOLDEN(GG[1])) u_b (
    .I1470(clk), .I1477(rst_a[1]), .start(st_a[1]), .dut_rst(drst_o[1]), .dut_in(din_b),
    .dut_out(dout[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .signature(sig_o[1]));
  nt_subckt_bist #(.N_IN(NN[2]), .PATTERNS(PP[2]), .LAT(LL[2]), .SEED(SS[2]), .GOLDEN(GG[2])) u_b2 (
    .I1470(clk), .I1477(rst_a[2]), .start(st_a[2]), .dut_rst(drst_o[2]), .dut_in(din_b2),
    .dut_out(dout[2]), .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]), .signature(sig_o[2]));
  nt_subckt_bist #(.N_IN(NN[3]), .PATTERNS(PP[3]), .LAT(LL[3]), .SEED(SS[3]), .GOLDEN(GG[3])) u_c (
    .I1470(clk), .I1477(rst_a[3]), .start(st_a[3]), .dut_rst(drst_o[3]), .dut_in(din_c),
    .dut_out(dout[3]), .busy(busy_o[3]), .done(done_o[3]), .pass(pass_o[3]), .signature(sig_o[3]));
  nt_subckt_bist #(.N_IN(NN[4]), .PATTERNS(PP[4]), .LAT(LL[4]), .SEED(SS[4]), .GOLDEN(GG[4])) u_d (
    .I1470(clk), .I1477(rst_a[4]), .start(st_a[4]), .dut_rst(drst_o[4]), .dut_in(din_d),
    .dut_out(dout[4]), .busy(busy_o[4]), .done(done_o[4]), .pass(pass_o[4]), .signature(sig_o[4]));

  // Model: t = cycles since the accepted start (-1 idle); done at t = P+LAT+3.
  int          t      [NI];
  logic        in_rst [NI];
  logic [15:0] esig   [NI];
  logic        epass  [NI];
  logic [15:0] rsig   [NI];
  logic [15:0] pats   [NI][1000];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < NI; i++) begin
      if (rst_a[i]) begin
        t[i] = -1; in_rst[i] = 1'b1; esig[i] = 16'h0000; epass[i] = 1'b0;
      end else begin
        in_rst[i] = 1'b0;
        if (t[i] < 0 || t[i] == PP[i] + LL[i] + 3) begin
          if (st_a[i]) t[i] = 0;
        end else begin
          t[i] = t[i] + 1;
        end
        if (t[i] == PP[i] + LL[i] + 3) begin
          esig[i] = rsig[i]; epass[i] = (rsig[i] == GG[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int i = 0; i < NI; i++) begin
        int dt;
        logic [15:0] ed, mask;
        dt   = PP[i] + LL[i] + 3;
        mask = 16'((1 << NN[i]) - 1);
        ed   = 16'h0000;
        if (t[i] >= 2 && t[i] <= PP[i] + 1) ed = pats[i][t[i]-2] & mask;
        else if (t[i] >= PP[i] + 2 && t[i] <= PP[i] + LL[i] + 1) ed = pats[i][PP[i]-1] & mask;
        chk($sformatf("cycle%0d inst%0d {rst,busy,done,pass,sig,din}", cyc, i),
            {drst_o[i], busy_o[i], done_o[i], pass_o[i], sig_o[i], din_o[i]},
            {in_rst[i] || t[i] == 0 || t[i] == 1, t[i] >= 0 && t[i] < dt, t[i] == dt,
             epass[i], esig[i], ed});
      end
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      logic [15:0] g;
      t[i] = -1; in_rst[i] = 1'b0; esig[i] = 16'h0000; epass[i] = 1'b0;
      g = (SS[i] == 16'h0000) ? 16'h0001 : SS[i];
      for (int j = 0; j < PP[i]; j++) begin
        pats[i][j] = g;
        g = nxt(g, 1'b0);
      end
      rsig[i] = ref_sig(SS[i], PP[i], MD[i]);
    end
    chk("model step ACE1", nxt(16'hACE1, 1'b0), 16'h59C3);
    chk("model step 59C3", nxt(16'h59C3, 1'b0), 16'hB387);
    chk("model step 8000", nxt(16'h8000, 1'b0), 16'h0001);
    chk("model misr in",   nxt(16'h0000, 1'b1), 16'h0001);
    chk("model zero resp", ref_sig(16'hACE1, 1000, 0), 16'h0000);

    fork
      begin : blk_a
        at(2);
        chk("A reset dut_rst", drst_o[0], 1);
        chk("A reset sig", sig_o[0], 0);
        at(3); rst0 = 1'b0;
        at(4); chk("A dut_rst low after reset", drst_o[0], 0);
        at(9); chk("A idle busy", busy_o[0], 0); st0 = 1'b1;
        at(10); st0 = 1'b0;
        chk("A busy after edge 10", busy_o[0], 1);
        chk("A dut_rst after edge 10", drst_o[0], 1);
        at(12); chk("A pattern0", din_o[0], 5'b00001);
        at(13); chk("A pattern1", din_o[0], 5'b00011);
        at(14); chk("A pattern2", din_o[0], 5'b00111);
        at(1014); chk("A done early", done_o[0], 0);
        at(1015);
        chk("A done at 1015", done_o[0], 1);
        chk("A sig zero", sig_o[0], 16'h0000);
        chk("A pass", pass_o[0], 1);
        at(1020); st0 = 1'b1;
        at(1021); st0 = 1'b0;
        at(1522); rst0 = 1'b1; chk("A busy before reset", busy_o[0], 1);
        at(1523); rst0 = 1'b0;
        chk("A reset busy", busy_o[0], 0);
        chk("A reset done", done_o[0], 0);
        chk("A reset din", din_o[0], 0);
        at(1530); st0 = 1'b1;
        at(1531); st0 = 1'b0;
        at(2535); chk("A rerun done early", done_o[0], 0);
        at(2536);
        chk("A rerun done", done_o[0], 1);
        chk("A rerun sig", sig_o[0], 16'h0000);
        chk("A rerun pass", pass_o[0], 1);
      end
      begin : blk_b
        bit got;
        at(3); rstB = 1'b0;
        at(5); stB = 1'b1;
        at(6); stB = 1'b0;
        for (int k = 0; k < 15; k++) begin
          @(negedge clk);
          stB = 1'($urandom_range(0, 1));
        end
        stB = 1'b0;
        at(27);
        chk("B done", done_o[1], 1);
        chk("B sig", sig_o[1], rsig[1]);
        chk("B pass wrong golden", pass_o[1], 0);
        chk("B2 sig", sig_o[2], rsig[1]);
        chk("B2 pass", pass_o[2], 1);
        for (int k = 0; k < 300; k++) begin
          @(negedge clk);
          stB  = ($urandom_range(0, 3) == 0);
          rstB = ($urandom_range(0, 99) == 0);
        end
        stB = 1'b0; rstB = 1'b1;
        @(negedge clk); rstB = 1'b0; stB = 1'b1;
        @(negedge clk); stB = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
          @(negedge clk);
          if (done_o[1]) got = 1'b1;
          else stB = (k < 12) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        stB = 1'b0;
        chk("B final done within bound", got, 1);
        chk("B final sig", sig_o[1], rsig[1]);
        chk("B2 final pass", pass_o[2], 1);
      end
      begin : blk_c
        bit got;
        at(3); rstC = 1'b0;
        at(6); stC = 1'b1;
        at(7); stC = 1'b0;
        at(9); chk("C seed0 first pattern", din_o[3], 3'b001);
        at(40);
        for (int k = 0; k < 600; k++) begin
          @(negedge clk);
          stC  = ($urandom_range(0, 4) == 0);
          rstC = ($urandom_range(0, 149) == 0);
        end
        stC = 1'b0; rstC = 1'b1;
        @(negedge clk); rstC = 1'b0; stC = 1'b1;
        @(negedge clk); stC = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
          @(negedge clk);
          if (done_o[3]) got = 1'b1;
        end
        chk("C done within bound", got, 1);
        chk("C sig", sig_o[3], rsig[3]);
      end
      begin : blk_d
        at(3); rstD = 1'b0;
        at(4); stD = 1'b1;
        for (int r = 0; r < 3; r++) begin
          at(15 + 12 * r); chk($sformatf("D run%0d done early", r), done_o[4], 0);
          at(16 + 12 * r);
          chk($sformatf("D run%0d done", r), done_o[4], 1);
          chk($sformatf("D run%0d sig", r), sig_o[4], rsig[4]);
          at(17 + 12 * r);
          if (r < 2) chk($sformatf("D run%0d done one cycle", r), done_o[4], 0);
          else chk("D done held", done_o[4], 1);
          if (r == 1) stD = 1'b0;
        end
        at(45); chk("D done still held", done_o[4], 1);
      end
    join

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nt_subckt_bist.md
# nt_subckt_bist

Built-in self-test driver for the Nt-node benchmark subcircuits: the initiating end of the stimulus/response link into a subcircuit under test (DUT). It resets the DUT, drives pseudo-random patterns on the DUT's data inputs from an LFSR, and compacts the DUT's single output into a MISR signature. It then compares the signature with a golden value. It sits beside each DUT instance in the trojan-detection testbench harness, replacing file-driven stimulus for the Benchmark_testing1000 runs.

## Interface
- N_IN, 5: number of DUT data inputs driven (1..16).
- PATTERNS, 1000: patterns applied per run (≥1, fits in 16 bits).
- LAT, 2: DUT clock-to-output latency in cycles (0..7).
- SEED, 16'hACE1: LFSR seed; a value of 0 is replaced by 16'h0001.
- GOLDEN, 16'h0000: expected MISR signature.

Ports:
- I1470  in  1  clock; also forwarded to the DUT clock pin by the harness.
- I1477  in  1  reset, synchronous, active-high.
- start  in  1  run request, level-sampled.
- dut_rst  out  1  active-high reset to the DUT.
- dut_in  out  N_IN  pattern bits to the DUT.
- dut_out  in  1  DUT response bit.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next start.
- pass  out  1  signature == GOLDEN; valid while done=1.
- signature  out  16  final MISR value; valid while done=1.

## Operation
- FSM states: IDLE, DRST, RUN, FLUSH, CHECK, DONE.
- IDLE, start=1 → DRST. In DRST the block loads the LFSR with SEED, clears the MISR to 0, asserts dut_rst for 2 cycles, then → RUN.
- RUN lasts PATTERNS cycles. dut_in = lfsr[N_IN-1:0]. The LFSR advances every RUN cycle, then → FLUSH (LAT=0 skips FLUSH and goes straight to CHECK).
- FLUSH lasts LAT cycles. The LFSR holds and dut_in holds its last value. → CHECK.
- CHECK lasts 1 cycle. It registers signature and pass, then → DONE.
- DONE: done=1 and outputs hold. start=1 → DRST (new run). start=0 → stay in DONE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shift left, feedback into bit 0.
- MISR: same polynomial, shift left. Feedback XOR dut_out goes into bit 0.
- MISR enable: (RUN and run-cycle index ≥ LAT) or FLUSH. This gives exactly PATTERNS captures per run, each aligned to its own pattern.
- Cycle counter: 16 bits, cleared on every state entry.
- start is ignored in DRST, RUN, FLUSH and CHECK.
- busy is high in DRST, RUN, FLUSH and CHECK.
- dut_in is 0 outside DRST and RUN/FLUSH.

## Timing
- Reset values: state=IDLE, dut_rst=1 while I1477=1 and 0 afterwards, dut_in=0, busy=0, done=0, pass=0, signature=0, LFSR=SEED, MISR=0.
- Latency: if start is sampled high at edge k, busy=1 after edge k and dut_rst=1 for edges k+1..k+2. The first pattern appears after edge k+2.
- done=1 after edge k+PATTERNS+LAT+3.
- Reset mid-run: the next edge returns to IDLE with the reset values above. There is no partial signature and done is not asserted.
- start held high continuously gives back-to-back runs. DONE lasts exactly 1 cycle between runs.
- start and I1477 high together: reset wins.

## Structure
- A shared package `nt_bist_pkg` holds:
  - the state enum;
  - the LFSR/MISR tap constant 16'hB400;
  - the fixed DUT reset length (2).
- One sub-module, `nt_lfsr16`, with seed-load, advance enable and serial-in XOR port. It is instantiated twice: as the pattern generator with serial-in 0, and as the MISR with serial-in dut_out.
- FSM and counter live in the top.

## Test plan
- Stub DUT with dut_out tied 0, PATTERNS=1000, LAT=2, GOLDEN=0, start pulsed at edge 10:
  - busy=1 after edge 10;
  - done=1 after edge 1015;
  - signature=16'h0000 and pass=1.
- Stub DUT with dut_out = dut_in[0] delayed 2 cycles, PATTERNS=16, SEED=16'hACE1:
  - signature matches the bench's software LFSR/MISR model;
  - rerun with a different GOLDEN gives pass=0 with the same signature.
- SEED=0: first dut_in = 5'b00001 after DRST, and the LFSR never locks at zero.
- Assert I1477 at RUN cycle 500:
  - next cycle busy=0, done=0, dut_in=0, state IDLE;
  - a new start gives the same signature as an uninterrupted run.
- start held high for 3 runs with PATTERNS=8, LAT=0:
  - done pulses 1 cycle every 12 cycles;
  - all three signatures are identical.
- start toggled during RUN: no effect on the cycle count or the signature.
